// File: rtl/mdr_sequencer_if.sv
// Handshake and control bundle between the operation selector/datapath
// and the MULT/DIV/ROOT sequencer.
interface mdr_sequencer_if #(
    parameter int DW = 16
);
    localparam int IW = $clog2(DW);

    logic          i_start;
    logic [3:0]    i_op;
    logic          i_div_zero;
    logic          o_ready;
    logic          o_busy;
    logic          o_load;
    logic          o_shift_en;
    logic [3:0]    o_unit_sel;
    logic [IW-1:0] o_iter;
    logic          o_done;
    logic          o_error;

    modport master (
        output i_start, i_op, i_div_zero,
        input  o_ready, o_busy, o_load, o_shift_en, o_unit_sel, o_iter, o_done, o_error
    );

    modport slave (
        input  i_start, i_op, i_div_zero,
        output o_ready, o_busy, o_load, o_shift_en, o_unit_sel, o_iter, o_done, o_error
    );
endinterface

// File: rtl/mdr_sequencer.sv
// Control sequencer for an iterative multiply / divide / square-root datapath.
// Accepts a one-hot operation in IDLE, strobes the operand load, runs the
// selected unit for its iteration count and finishes with a done pulse.
// Illegal operations and division by zero skip straight to an error done.
module mdr_sequencer #(
    parameter int DW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    mdr_sequencer_if.slave  bus
);
    localparam int IW = $clog2(DW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [3:0] OP_MULT = 4'b0001;
    localparam logic [3:0] OP_DIV  = 4'b0010;
    localparam logic [3:0] OP_ROOT = 4'b0100;
    localparam logic [3:0] OP_NON  = 4'b1000;

    if (DW < 4 || (DW % 2) != 0) begin : g_bad_dw
        $error("mdr_sequencer: DW must be even and >= 4");
    end

    logic [1:0]    state;
    logic [3:0]    unit_sel;
    logic [IW-1:0] iter;
    logic          err_flag;
    logic [IW-1:0] last_iter;

    // Final iteration index of the accepted unit; ROOT needs half the passes.
    always_comb begin
        last_iter = IW'(DW - 1);
        if (unit_sel == OP_ROOT) begin
            last_iter = IW'(DW / 2 - 1);
        end
    end

    // Sequencer state, captured operation, iteration counter and error flag.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            unit_sel <= 4'b0000;
            iter     <= '0;
            err_flag <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        if (!$onehot(bus.i_op)) begin
                            state    <= S_DONE;
                            unit_sel <= 4'b0000;
                            err_flag <= 1'b1;
                        end else if (bus.i_op == OP_DIV && bus.i_div_zero) begin
                            state    <= S_DONE;
                            unit_sel <= OP_DIV;
                            err_flag <= 1'b1;
                        end else begin
                            state    <= S_LOAD;
                            unit_sel <= bus.i_op;
                        end
                    end
                end
                S_LOAD: begin
                    iter  <= '0;
                    state <= (unit_sel == OP_NON) ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    // Counter returns to zero on exit so o_iter reads 0 outside RUN.
                    if (iter == last_iter) begin
                        iter  <= '0;
                        state <= S_DONE;
                    end else begin
                        iter <= iter + 1'b1;
                    end
                end
                S_DONE: begin
                    state    <= S_IDLE;
                    err_flag <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Status and strobes decode directly from the state; only one state is
    // active at a time, which keeps load/shift/done mutually exclusive.
    always_comb begin
        bus.o_ready    = (state == S_IDLE);
        bus.o_busy     = (state == S_LOAD) || (state == S_RUN);
        bus.o_load     = (state == S_LOAD);
        bus.o_shift_en = (state == S_RUN);
        bus.o_done     = (state == S_DONE);
        bus.o_error    = (state == S_DONE) && err_flag;
        bus.o_unit_sel = unit_sel;
        bus.o_iter     = iter;
    end

    // OP_MULT is listed for completeness of the opcode map.
    logic unused_op;
    assign unused_op = ^OP_MULT;

endmodule

// File: tb/tb_mdr_sequencer.sv
// Directed bench for mdr_sequencer at DW=16.
module tb_mdr_sequencer;
    logic clk;
    logic rst_n;

    mdr_sequencer_if #(.DW(16)) bus ();

    mdr_sequencer #(.DW(16)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    // {ready, busy, load, shift_en, done, error}
    logic [5:0] st;
    assign st = {bus.o_ready, bus.o_busy, bus.o_load, bus.o_shift_en, bus.o_done, bus.o_error};

    localparam logic [5:0] ST_IDLE = 6'b100000;
    localparam logic [5:0] ST_LOAD = 6'b011000;
    localparam logic [5:0] ST_RUN  = 6'b010100;
    localparam logic [5:0] ST_DONE = 6'b000010;
    localparam logic [5:0] ST_ERR  = 6'b000011;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_start = 1'b1;
        bus.i_op = 4'b0001;
        bus.i_div_zero = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (st !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_status: got %b want %b", st, ST_IDLE);
        end
        n_cmp++;
        if (bus.o_unit_sel !== 4'b0000 || bus.o_iter !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_regs: got sel=%b iter=%0d want sel=0000 iter=0", bus.o_unit_sel, bus.o_iter);
        end
        rst_n = 1'b1;
        bus.i_start = 1'b0;
        tick();
        n_cmp++;
        if (st !== ST_IDLE) begin
            n_fail++;
            $display("FAIL reset_release: got %b want %b", st, ST_IDLE);
        end
    endtask

    // Start one operation from IDLE and follow it cycle by cycle to IDLE.
    task automatic exercise_op(input string name, input logic [3:0] op, input logic dz,
                               input logic [3:0] exp_sel, input int exp_n,
                               input logic exp_err, input logic toggle);
        bus.i_start = 1'b1;
        bus.i_op = op;
        bus.i_div_zero = dz;
        tick();
        bus.i_start = 1'b0;
        if (exp_err) begin
            n_cmp++;
            if (st !== ST_ERR || bus.o_unit_sel !== exp_sel) begin
                n_fail++;
                $display("FAIL %s_err_done: got st=%b sel=%b want st=%b sel=%b", name, st, bus.o_unit_sel, ST_ERR, exp_sel);
            end
        end else begin
            n_cmp++;
            if (st !== ST_LOAD || bus.o_unit_sel !== exp_sel || bus.o_iter !== 4'd0) begin
                n_fail++;
                $display("FAIL %s_load: got st=%b sel=%b iter=%0d want st=%b sel=%b iter=0", name, st, bus.o_unit_sel, bus.o_iter, ST_LOAD, exp_sel);
            end
            for (int k = 0; k < exp_n; k++) begin
                tick();
                n_cmp++;
                if (st !== ST_RUN || bus.o_iter !== 4'(k) || bus.o_unit_sel !== exp_sel) begin
                    n_fail++;
                    $display("FAIL %s_run%0d: got st=%b iter=%0d sel=%b want st=%b iter=%0d sel=%b", name, k, st, bus.o_iter, bus.o_unit_sel, ST_RUN, k, exp_sel);
                end
                if (toggle) begin
                    bus.i_op = (k % 2 == 0) ? 4'b0010 : 4'b0001;
                    bus.i_div_zero = 1'b1;
                end
            end
            tick();
            n_cmp++;
            if (st !== ST_DONE || bus.o_iter !== 4'd0) begin
                n_fail++;
                $display("FAIL %s_done: got st=%b iter=%0d want st=%b iter=0", name, st, bus.o_iter, ST_DONE);
            end
        end
        tick();
        n_cmp++;
        if (st !== ST_IDLE || bus.o_unit_sel !== exp_sel) begin
            n_fail++;
            $display("FAIL %s_idle: got st=%b sel=%b want st=%b sel=%b", name, st, bus.o_unit_sel, ST_IDLE, exp_sel);
        end
        bus.i_div_zero = 1'b0;
    endtask

    task automatic test_mult();
        exercise_op("mult", 4'b0001, 1'b0, 4'b0001, 16, 1'b0, 1'b0);
    endtask

    task automatic test_root_non();
        exercise_op("root", 4'b0100, 1'b0, 4'b0100, 8, 1'b0, 1'b0);
        exercise_op("non", 4'b1000, 1'b0, 4'b1000, 0, 1'b0, 1'b0);
        exercise_op("div", 4'b0010, 1'b0, 4'b0010, 16, 1'b0, 1'b0);
    endtask

    task automatic test_errors();
        exercise_op("divzero", 4'b0010, 1'b1, 4'b0010, 0, 1'b1, 1'b0);
        exercise_op("op0110", 4'b0110, 1'b0, 4'b0000, 0, 1'b1, 1'b0);
        exercise_op("op0000", 4'b0000, 1'b0, 4'b0000, 0, 1'b1, 1'b0);
        // A clean op afterwards must not carry the error flag along.
        exercise_op("non_after_err", 4'b1000, 1'b0, 4'b1000, 0, 1'b0, 1'b0);
    endtask

    task automatic test_op_toggle();
        exercise_op("root_toggle", 4'b0100, 1'b0, 4'b0100, 8, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        bus.i_start = 1'b1;
        bus.i_op = 4'b0001;
        bus.i_div_zero = 1'b0;
        for (int op_n = 0; op_n < 2; op_n++) begin
            tick();
            n_cmp++;
            if (st !== ST_LOAD) begin
                n_fail++;
                $display("FAIL b2b%0d_load: got %b want %b", op_n, st, ST_LOAD);
            end
            for (int k = 0; k < 16; k++) begin
                tick();
                n_cmp++;
                if (st !== ST_RUN || bus.o_iter !== 4'(k)) begin
                    n_fail++;
                    $display("FAIL b2b%0d_run%0d: got st=%b iter=%0d want st=%b iter=%0d", op_n, k, st, bus.o_iter, ST_RUN, k);
                end
            end
            tick();
            n_cmp++;
            if (st !== ST_DONE) begin
                n_fail++;
                $display("FAIL b2b%0d_done: got %b want %b", op_n, st, ST_DONE);
            end
            tick();
            n_cmp++;
            if (st !== ST_IDLE) begin
                n_fail++;
                $display("FAIL b2b%0d_idle_gap: got %b want %b", op_n, st, ST_IDLE);
            end
        end
        bus.i_start = 1'b0;
        tick();
        n_cmp++;
        if (st !== ST_IDLE) begin
            n_fail++;
            $display("FAIL b2b_stop: got %b want %b", st, ST_IDLE);
        end
    endtask

    task automatic test_reset_mid_run();
        bus.i_start = 1'b1;
        bus.i_op = 4'b0001;
        tick();
        bus.i_start = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            tick();
        end
        n_cmp++;
        if (st !== ST_RUN || bus.o_iter !== 4'd5) begin
            n_fail++;
            $display("FAIL abort_pre: got st=%b iter=%0d want st=%b iter=5", st, bus.o_iter, ST_RUN);
        end
        rst_n = 1'b0;
        bus.i_start = 1'b1;
        tick();
        n_cmp++;
        if (st !== ST_IDLE || bus.o_iter !== 4'd0 || bus.o_unit_sel !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_reset: got st=%b iter=%0d sel=%b want st=%b iter=0 sel=0000", st, bus.o_iter, bus.o_unit_sel, ST_IDLE);
        end
        rst_n = 1'b1;
        bus.i_start = 1'b0;
        tick();
        n_cmp++;
        if (st !== ST_IDLE) begin
            n_fail++;
            $display("FAIL abort_release: got %b want %b", st, ST_IDLE);
        end
        exercise_op("mult_after_abort", 4'b0001, 1'b0, 4'b0001, 16, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.i_start = 1'b0;
        bus.i_op = 4'b0000;
        bus.i_div_zero = 1'b0;
        test_reset();
        test_mult();
        test_root_non();
        test_errors();
        test_op_toggle();
        test_back_to_back();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
